ctrl_contador_bombas: RTL and testbench
=======================================

Name: ctrl_contador_bombas

Overview:
- Sequencer for the two-digit bomb-count display decoder.
- Holds the configured bomb count and tracks flags placed during play.
- Presents the remaining-bomb value on a 6-bit bus feeding the decoder's `entrada_bombas` input.
- Drives a blank/blink control for the displays through the config, play and end-of-game phases of the minesweeper top level.

Parameters:
- `MAX_BOMBAS`, 63: upper clamp for the configured bomb count; must be ≤ 63.
- `MAX_CELDAS`, 64: board cell count; saturation limit of the flag counter.
- `PARPADEO_CICLOS`, 25000000: clock cycles per blink half-period in `FIN`; ≥ 2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `inicio` in 1: one-cycle pulse; starts a game.
- `cfg_bombas` in 6: requested bomb count (switches), sampled only in `CONFIG` on `inicio`.
- `bandera_puesta` in 1: one-cycle pulse; a flag was placed.
- `bandera_quitada` in 1: one-cycle pulse; a flag was removed.
- `fin_juego` in 1: one-cycle pulse; game won or lost.
- `entrada_bombas` out 6: remaining-bomb value to the seg7 decoder.
- `apagar_display` out 1: 1 = top level forces both digits blank.
- `estado` out 2: current FSM state code.

Behaviour:
- Reset (`rst` = 1 at a clock edge, in any state, including mid-game):
  - state = `CONFIG`; `bombas` = 0; `banderas` = 0; blink counter = 0.
  - `entrada_bombas` = 0; `apagar_display` = 0; `estado` = 0.
- FSM states and codes: `CONFIG`=0, `JUEGO`=1, `FIN`=2. Code 3 is unused and returns to `CONFIG` on the next edge.
- `CONFIG`:
  - `entrada_bombas` shows the live clamped `cfg_bombas`, registered with 1-cycle latency, so the player previews the count.
  - Clamp rule: 0 → 1; values above `MAX_BOMBAS` → `MAX_BOMBAS`.
  - On `inicio`: `bombas` ← clamped `cfg_bombas`, `banderas` ← 0, next state `JUEGO`.
  - `bandera_*` and `fin_juego` are ignored.
- `JUEGO`:
  - `bandera_puesta` alone: `banderas` +1, saturating at `MAX_CELDAS`.
  - `bandera_quitada` alone: `banderas` −1, saturating at 0.
  - Both flag pulses in the same cycle: no change.
  - `entrada_bombas` = `bombas` − `banderas` when `bombas` > `banderas`, else 0. Never wraps negative.
  - The output register updates on the edge after the `banderas` update, giving 1-cycle latency from pulse to output.
  - `cfg_bombas` changes are ignored.
  - `inicio` is ignored in `JUEGO`.
  - `fin_juego` → `FIN`. It takes priority over flag pulses in the same cycle; those pulses are dropped.
- `FIN`:
  - `entrada_bombas` is frozen at its last `JUEGO` value.
  - Blink counter counts 0..`PARPADEO_CICLOS`−1, then wraps to 0 and toggles `apagar_display`.
  - On entry to `FIN`, the counter is cleared and `apagar_display` = 0.
  - On `inicio`: → `CONFIG`, `apagar_display` ← 0, `banderas` ← 0.
- `apagar_display` is 0 in every state except while blinking in `FIN`.
- Width rules:
  - `banderas` is 7 bits.
  - Subtraction is done in 7 bits; the result is truncated to 6 bits only after the saturation compare.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Package `bombas_pkg`:
  - enum `estado_t` {`CONFIG`, `JUEGO`, `FIN`} with the 2-bit codes above.
  - Constants `ANCHO_BOMBAS`=6 and `ANCHO_BANDERAS`=7.
  - Clamp function `limitar_bombas`.
- One sub-module, `divisor_parpadeo`:
  - Parameterised terminal counter with clear input; emits a one-cycle tick at wrap.
  - The parent toggles `apagar_display` on each tick.

Test Plan:
- Reset: `rst`=1 mid-`JUEGO` with `banderas`=5 → next cycle `estado`=0, `entrada_bombas`=0, `apagar_display`=0.
- Config clamp: `cfg_bombas`=0 → `entrada_bombas`=1; `cfg_bombas`=10 then `inicio` → `estado`=1, `entrada_bombas`=10.
- Flag arithmetic (`bombas`=10): 3×`bandera_puesta` → 7; 1×`bandera_quitada` → 8; both pulses together → stays 8.
- Flag saturation (`bombas`=2): 4×`bandera_puesta` → `entrada_bombas`=0 (not 62); then 2×`bandera_quitada` → still 0 (`banderas`=2); one more `bandera_quitada` → 1.
- End-of-game priority: `fin_juego` and `bandera_puesta` in the same cycle at value 4 → `estado`=2, `entrada_bombas` stays 4.
- Blink and restart: with `PARPADEO_CICLOS`=4, `apagar_display` toggles every 4 cycles in `FIN`; `inicio` → `estado`=0, `apagar_display`=0.

Source files
------------

// File: rtl/bombas_pkg.sv
// Shared types and helpers for the bomb-count display sequencer.
// Contents:
//   estado_t        - sequencer states with their 2-bit codes
//   ANCHO_BOMBAS    - width of the bomb count / display value
//   ANCHO_BANDERAS  - width of the flag counter (one extra bit so it can exceed 63)
//   limitar_bombas  - clamps a requested bomb count into 1..maximo
package bombas_pkg;

   localparam int ANCHO_BOMBAS   = 6;
   localparam int ANCHO_BANDERAS = 7;

   typedef enum logic [1:0] {
      CONFIG = 2'd0,
      JUEGO  = 2'd1,
      FIN    = 2'd2
   } estado_t;

   // A game always has at least one bomb; requests above the board limit are capped.
   function automatic logic [ANCHO_BOMBAS-1:0] limitar_bombas(
      input logic [ANCHO_BOMBAS-1:0] valor,
      input logic [ANCHO_BOMBAS-1:0] maximo
   );
      logic [ANCHO_BOMBAS-1:0] res;
      if (valor == '0) begin
         res = ANCHO_BOMBAS'(1);
      end else if (valor > maximo) begin
         res = maximo;
      end else begin
         res = valor;
      end
      return res;
   endfunction

endpackage

// File: rtl/divisor_parpadeo.sv
// Terminal counter that paces the display blink.
// Ports:
//   clk  - system clock
//   clr  - synchronous clear, holds the count at 0 while asserted
//   tick - one-cycle pulse on the cycle the count sits at CICLOS-1 (wraps next edge)
module divisor_parpadeo #(
   parameter int CICLOS = 25000000
) (
   input  logic clk,
   input  logic clr,
   output logic tick
);

   localparam int W = (CICLOS > 2) ? $clog2(CICLOS) : 1;
   localparam logic [W-1:0] ULTIMO = W'(CICLOS - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q + W'(1);
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q == ULTIMO) begin
         tick  = 1'b1;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ctrl_contador_bombas.sv
// Sequencer for the two-digit remaining-bomb display.
// Holds the configured bomb count, tracks flags placed during play and
// drives the blank/blink control across the config, play and end phases.
// Ports:
//   clk             - system clock
//   rst             - synchronous active-high reset
//   inicio          - pulse: start a game (CONFIG) / return to config (FIN)
//   cfg_bombas      - requested bomb count, only used in CONFIG
//   bandera_puesta  - pulse: a flag was placed
//   bandera_quitada - pulse: a flag was removed
//   fin_juego       - pulse: game won or lost
//   entrada_bombas  - registered remaining-bomb value for the seg7 decoder
//   apagar_display  - registered blank request for both digits
//   estado          - registered state code (0 CONFIG, 1 JUEGO, 2 FIN)
module ctrl_contador_bombas
   import bombas_pkg::*;
#(
   parameter int MAX_BOMBAS      = 63,
   parameter int MAX_CELDAS      = 64,
   parameter int PARPADEO_CICLOS = 25000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inicio,
   input  logic [ANCHO_BOMBAS-1:0] cfg_bombas,
   input  logic                    bandera_puesta,
   input  logic                    bandera_quitada,
   input  logic                    fin_juego,
   output logic [ANCHO_BOMBAS-1:0] entrada_bombas,
   output logic                    apagar_display,
   output logic [1:0]              estado
);

   localparam logic [ANCHO_BOMBAS-1:0]   MAX_B = ANCHO_BOMBAS'(MAX_BOMBAS);
   localparam logic [ANCHO_BANDERAS-1:0] MAX_F = ANCHO_BANDERAS'(MAX_CELDAS);

   estado_t                   state_q,    state_d;
   logic [ANCHO_BOMBAS-1:0]   bombas_q,   bombas_d;
   logic [ANCHO_BANDERAS-1:0] banderas_q, banderas_d;
   logic [ANCHO_BOMBAS-1:0]   entrada_q,  entrada_d;
   logic                      apagar_q,   apagar_d;

   logic                      clr_parpadeo;
   logic                      tick_parpadeo;
   logic [ANCHO_BANDERAS-1:0] bombas_ext;
   logic [ANCHO_BOMBAS-1:0]   restantes;

   // The blink counter only runs in FIN, so it always starts from 0 on entry.
   assign clr_parpadeo = rst || (state_q != FIN);

   divisor_parpadeo #(
      .CICLOS (PARPADEO_CICLOS)
   ) u_divisor (
      .clk  (clk),
      .clr  (clr_parpadeo),
      .tick (tick_parpadeo)
   );

   // Compare in 7 bits so more flags than bombs saturates to 0 instead of wrapping;
   // truncate to the display width only after the compare.
   always_comb begin
      bombas_ext = {1'b0, bombas_q};
      restantes  = '0;
      if (bombas_ext > banderas_q) begin
         restantes = ANCHO_BOMBAS'(bombas_ext - banderas_q);
      end
   end

   always_comb begin
      state_d    = state_q;
      bombas_d   = bombas_q;
      banderas_d = banderas_q;
      entrada_d  = entrada_q;
      apagar_d   = 1'b0;

      case (state_q)
         CONFIG: begin
            entrada_d = limitar_bombas(cfg_bombas, MAX_B);
            if (inicio) begin
               bombas_d   = limitar_bombas(cfg_bombas, MAX_B);
               banderas_d = '0;
               state_d    = JUEGO;
            end
         end
         JUEGO: begin
            entrada_d = restantes;
            // End of game wins over any flag pulse in the same cycle.
            if (fin_juego) begin
               state_d = FIN;
            end else if (bandera_puesta && !bandera_quitada) begin
               if (banderas_q < MAX_F) begin
                  banderas_d = banderas_q + ANCHO_BANDERAS'(1);
               end
            end else if (bandera_quitada && !bandera_puesta) begin
               if (banderas_q != '0) begin
                  banderas_d = banderas_q - ANCHO_BANDERAS'(1);
               end
            end
         end
         FIN: begin
            // entrada_bombas stays frozen at the last play value.
            apagar_d = tick_parpadeo ? ~apagar_q : apagar_q;
            if (inicio) begin
               apagar_d   = 1'b0;
               banderas_d = '0;
               state_d    = CONFIG;
            end
         end
         default: begin
            state_d = CONFIG;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CONFIG;
         bombas_q   <= '0;
         banderas_q <= '0;
         entrada_q  <= '0;
         apagar_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bombas_q   <= bombas_d;
         banderas_q <= banderas_d;
         entrada_q  <= entrada_d;
         apagar_q   <= apagar_d;
      end
   end

   assign entrada_bombas = entrada_q;
   assign apagar_display = apagar_q;
   assign estado         = state_q;

endmodule

// File: tb/tb_ctrl_contador_bombas.sv
// Bench for ctrl_contador_bombas: table of {inputs, expected outputs} rows,
// expected values queued when a row is driven and compared after the edge.
module tb_ctrl_contador_bombas;

   logic       clk = 1'b0;
   logic       rst;
   logic       inicio;
   logic [5:0] cfg_bombas;
   logic       bandera_puesta;
   logic       bandera_quitada;
   logic       fin_juego;
   logic [5:0] entrada_bombas;
   logic       apagar_display;
   logic [1:0] estado;

   ctrl_contador_bombas #(
      .MAX_BOMBAS      (40),
      .MAX_CELDAS      (8),
      .PARPADEO_CICLOS (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .inicio          (inicio),
      .cfg_bombas      (cfg_bombas),
      .bandera_puesta  (bandera_puesta),
      .bandera_quitada (bandera_quitada),
      .fin_juego       (fin_juego),
      .entrada_bombas  (entrada_bombas),
      .apagar_display  (apagar_display),
      .estado          (estado)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       ini;
      logic [5:0] cfg;
      logic       bp;
      logic       bq;
      logic       fin;
      logic [5:0] ent;
      logic       ap;
      logic [1:0] est;
   } vec_t;

   typedef struct {
      logic [5:0] ent;
      logic       ap;
      logic [1:0] est;
      int         id;
   } esp_t;

   vec_t tabla[$];
   esp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic v(input logic r, input logic i, input logic [5:0] c,
                    input logic p, input logic q, input logic f,
                    input logic [5:0] e, input logic a, input logic [1:0] s);
      vec_t t;
      t.rst = r; t.ini = i; t.cfg = c; t.bp = p; t.bq = q; t.fin = f;
      t.ent = e; t.ap = a; t.est = s;
      tabla.push_back(t);
   endtask

   task automatic aplicar(input vec_t t, input int id);
      esp_t x;
      esp_t y;
      rst             = t.rst;
      inicio          = t.ini;
      cfg_bombas      = t.cfg;
      bandera_puesta  = t.bp;
      bandera_quitada = t.bq;
      fin_juego       = t.fin;
      x.ent = t.ent; x.ap = t.ap; x.est = t.est; x.id = id;
      sb.push_back(x);
      @(posedge clk);
      #1;
      y = sb.pop_front();
      checks += 3;
      if (entrada_bombas !== y.ent) begin
         errors++;
         $display("FAIL row%0d entrada_bombas: got %0d expected %0d", y.id, entrada_bombas, y.ent);
      end
      if (apagar_display !== y.ap) begin
         errors++;
         $display("FAIL row%0d apagar_display: got %0b expected %0b", y.id, apagar_display, y.ap);
      end
      if (estado !== y.est) begin
         errors++;
         $display("FAIL row%0d estado: got %0d expected %0d", y.id, estado, y.est);
      end
   endtask

   initial begin
      vec_t h;
      int   n;
      rst = 1'b1; inicio = 1'b0; cfg_bombas = '0;
      bandera_puesta = 1'b0; bandera_quitada = 1'b0; fin_juego = 1'b0;

      //  rst ini cfg bp bq fin | ent ap est
      v(1, 0,  0, 0, 0, 0,   0, 0, 0);  // reset
      v(0, 0,  0, 0, 0, 0,   1, 0, 0);  // clamp 0 -> 1
      v(0, 0, 50, 0, 0, 0,  40, 0, 0);  // clamp above max
      v(0, 0, 10, 0, 0, 0,  10, 0, 0);
      v(0, 1, 10, 0, 0, 0,  10, 0, 1);  // start, bombas=10
      v(0, 0,  0, 0, 0, 0,  10, 0, 1);  // cfg ignored
      v(0, 0,  0, 1, 0, 0,  10, 0, 1);
      v(0, 0,  0, 1, 0, 0,   9, 0, 1);
      v(0, 0,  0, 1, 0, 0,   8, 0, 1);
      v(0, 0,  0, 0, 0, 0,   7, 0, 1);  // 3 flags -> 7
      v(0, 0,  0, 0, 1, 0,   7, 0, 1);
      v(0, 0,  0, 0, 0, 0,   8, 0, 1);  // 1 removed -> 8
      v(0, 0,  0, 1, 1, 0,   8, 0, 1);  // both together
      v(0, 0,  0, 0, 0, 0,   8, 0, 1);
      v(0, 1,  0, 0, 0, 0,   8, 0, 1);  // inicio ignored
      v(0, 0,  0, 1, 0, 0,   8, 0, 1);
      v(0, 0,  0, 1, 0, 0,   7, 0, 1);
      v(0, 0,  0, 1, 0, 0,   6, 0, 1);  // banderas now 5
      v(1, 0,  0, 0, 0, 0,   0, 0, 0);  // reset mid-game
      v(0, 0,  2, 0, 0, 0,   2, 0, 0);
      v(0, 1,  2, 0, 0, 0,   2, 0, 1);  // bombas=2
      v(0, 0,  0, 1, 0, 0,   2, 0, 1);
      v(0, 0,  0, 1, 0, 0,   1, 0, 1);
      v(0, 0,  0, 1, 0, 0,   0, 0, 1);
      v(0, 0,  0, 1, 0, 0,   0, 0, 1);
      v(0, 0,  0, 0, 0, 0,   0, 0, 1);  // 2-4 stays 0
      v(0, 0,  0, 0, 1, 0,   0, 0, 1);
      v(0, 0,  0, 0, 1, 0,   0, 0, 1);
      v(0, 0,  0, 0, 0, 0,   0, 0, 1);  // banderas=2
      v(0, 0,  0, 0, 1, 0,   0, 0, 1);
      v(0, 0,  0, 0, 0, 0,   1, 0, 1);  // banderas=1 -> 1
      v(0, 0,  0, 0, 0, 1,   1, 0, 2);  // end
      v(0, 1,  0, 0, 0, 0,   1, 0, 0);  // back to config
      v(0, 0,  6, 0, 0, 0,   6, 0, 0);
      v(0, 1,  6, 0, 0, 0,   6, 0, 1);
      v(0, 0,  0, 1, 0, 0,   6, 0, 1);
      v(0, 0,  0, 1, 0, 0,   5, 0, 1);
      v(0, 0,  0, 0, 0, 0,   4, 0, 1);
      v(0, 0,  0, 1, 0, 1,   4, 0, 2);  // fin beats flag
      v(0, 0,  0, 0, 0, 0,   4, 0, 2);  // blink k=1
      v(0, 0,  0, 0, 0, 0,   4, 0, 2);
      v(0, 0,  0, 0, 0, 0,   4, 0, 2);
      v(0, 0,  0, 0, 0, 0,   4, 1, 2);  // k=4 toggle
      v(0, 0,  0, 0, 0, 0,   4, 1, 2);
      v(0, 0,  0, 0, 0, 0,   4, 1, 2);
      v(0, 0,  0, 0, 0, 0,   4, 1, 2);
      v(0, 0,  0, 0, 0, 0,   4, 0, 2);  // k=8 toggle
      v(0, 0, 33, 1, 0, 0,   4, 0, 2);  // flag ignored in FIN
      v(0, 0,  0, 0, 0, 0,   4, 0, 2);
      v(0, 0,  0, 0, 0, 0,   4, 0, 2);
      v(0, 0,  0, 0, 0, 0,   4, 1, 2);  // k=12 toggle
      v(0, 1,  0, 0, 0, 0,   4, 0, 0);  // restart clears blank
      v(0, 0,  6, 0, 0, 0,   6, 0, 0);

      for (int i = 0; i < tabla.size(); i++) begin
         aplicar(tabla[i], i);
      end

      // Flag counter saturation at MAX_CELDAS (8) with bombas=40.
      n = 100;
      h = '{rst:0, ini:1, cfg:40, bp:0, bq:0, fin:0, ent:40, ap:0, est:1};
      aplicar(h, n++);
      for (int i = 0; i < 10; i++) begin
         h = '{rst:0, ini:0, cfg:0, bp:1, bq:0, fin:0,
               ent:6'(40 - ((i < 8) ? i : 8)), ap:0, est:1};
         aplicar(h, n++);
      end
      h = '{rst:0, ini:0, cfg:0, bp:0, bq:0, fin:0, ent:32, ap:0, est:1};
      aplicar(h, n++);
      h = '{rst:0, ini:0, cfg:0, bp:0, bq:1, fin:0, ent:32, ap:0, est:1};
      aplicar(h, n++);
      h = '{rst:0, ini:0, cfg:0, bp:0, bq:0, fin:0, ent:33, ap:0, est:1};
      aplicar(h, n++);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
